// File: rtl/conv_pkg.sv
// Shared constants for the convolution front end (window generator and muladd MAC).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    // Pixel width; matches the muladd operand width.
    localparam int DATA_W = 17;

    // Default image geometry.
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    // Kernel edge length shared with muladd, and the resulting tap count.
    localparam int KSIZE = 3;
    localparam int NTAPS = KSIZE * KSIZE;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle of conv_window_gen.
// Latency: n/a (wires only).
// Backpressure: none; the source streams pixels, the sink must take every window.
// Ports: en, pix_in, pix_valid (toward the generator); subimage0..8, win_valid,
// frame_done (from the generator). master = pixel source / window sink, slave = generator.
interface conv_window_gen_if import conv_pkg::*; #(
    parameter int DATA_W = conv_pkg::DATA_W
);
    logic              en;
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;

    logic [DATA_W-1:0] subimage0;
    logic [DATA_W-1:0] subimage1;
    logic [DATA_W-1:0] subimage2;
    logic [DATA_W-1:0] subimage3;
    logic [DATA_W-1:0] subimage4;
    logic [DATA_W-1:0] subimage5;
    logic [DATA_W-1:0] subimage6;
    logic [DATA_W-1:0] subimage7;
    logic [DATA_W-1:0] subimage8;
    logic              win_valid;
    logic              frame_done;

    modport master (
        output en, pix_in, pix_valid,
        input  subimage0, subimage1, subimage2, subimage3, subimage4,
               subimage5, subimage6, subimage7, subimage8,
               win_valid, frame_done
    );

    modport slave (
        input  en, pix_in, pix_valid,
        output subimage0, subimage1, subimage2, subimage3, subimage4,
               subimage5, subimage6, subimage7, subimage8,
               win_valid, frame_done
    );
endinterface

// File: rtl/line_fifo.sv
// Fixed-length delay line: dout is the din value written DEPTH enabled cycles ago.
// Latency: DEPTH enabled cycles; dout is a combinational read of the slot about to be overwritten.
// Backpressure: none; en low freezes the pointer and contents.
// Ports: clk, rst (sync, active high, pointer only), en, din, dout.
module line_fifo import conv_pkg::*; #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int DEPTH  = IMG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;

    // Read-before-write on a single pointer: the slot under ptr holds the
    // oldest sample, which is exactly DEPTH writes old.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Contents are never cleared; every slot is rewritten before it is used
    // in a valid window.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, fully-inside 3x3 neighbourhoods out.
// Latency: 1 cycle from accepted pixel to window/win_valid.
// Backpressure: none; en low or pix_valid low stalls losslessly, sink must take every window.
// Ports: clk, rst (sync, active high, wins over en), bus (slave: en, pix_in, pix_valid in;
// subimage0..8, win_valid, frame_done out).
module conv_window_gen import conv_pkg::*; #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KSIZE - 1);

    // Position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic accept;
    logic in_window;
    logic last_pix;

    logic [DATA_W-1:0] lb0_out;
    logic [DATA_W-1:0] lb1_out;

    logic [DATA_W-1:0] win [KSIZE][KSIZE];
    logic              win_valid_q;
    logic              frame_done_q;

    assign accept    = bus.en && bus.pix_valid;
    // Windows that straddle a row boundary (col < 2) or reach above the
    // frame (row < 2) hold stale columns and are never flagged.
    assign in_window = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

    // Chained line buffers: lb0 yields row r-1, lb1 yields row r-2, same column.
    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (bus.pix_in),
        .dout (lb0_out)
    );

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win[i][j] <= '0;
                end
            end
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= accept && in_window;
            frame_done_q <= accept && last_pix;
            if (accept) begin
                // Shift one column left, then load the new right column
                // oldest row on top.
                for (int i = 0; i < KSIZE; i++) begin
                    for (int j = 0; j < KSIZE - 1; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                end
                win[0][KSIZE-1] <= lb1_out;
                win[1][KSIZE-1] <= lb0_out;
                win[2][KSIZE-1] <= bus.pix_in;
            end
        end
    end

    assign bus.subimage0  = win[0][0];
    assign bus.subimage1  = win[0][1];
    assign bus.subimage2  = win[0][2];
    assign bus.subimage3  = win[1][0];
    assign bus.subimage4  = win[1][1];
    assign bus.subimage5  = win[1][2];
    assign bus.subimage6  = win[2][0];
    assign bus.subimage7  = win[2][1];
    assign bus.subimage8  = win[2][2];
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the `muladd` convolution MAC. It accepts one raster-order pixel per cycle, keeps the two previous image rows in internal line buffers, and presents each complete 3x3 neighbourhood as nine parallel pixels `subimage0..subimage8`, together with a one-cycle `win_valid` strobe. Only windows lying fully inside the image are produced: no padding, stride 1.

## Interface
- `DATA_W`, 17, pixel width; matches the `muladd` operand width.
- `IMG_W`, 28, image width in pixels; must be ≥ 3.
- `IMG_H`, 28, image height in rows; must be ≥ 3.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  stage enable; when low, all state and outputs hold.
- `pix_in`  in  DATA_W  incoming pixel, raster order (row-major, left to right).
- `pix_valid`  in  1  `pix_in` is meaningful; it is accepted on a rising edge where `en && pix_valid`.
- `subimage0..subimage8`  out  DATA_W each  window, row-major. `subimage0` = (r-2,c-2), `subimage4` = centre (r-1,c-1), `subimage8` = newest pixel (r,c).
- `win_valid`  out  1  window outputs hold a new complete window; one-cycle pulse.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) track the position of the next pixel to be accepted.
- On each accepted pixel:
  - Each line buffer advances by one.
    - Line buffer 0 outputs the pixel from row r-1, same column.
    - Line buffer 1 outputs the pixel from row r-2, same column.
  - The 3x3 window register shifts one column left.
  - The new right column is loaded as {lb1_out, lb0_out, pix_in}, which feed `subimage2`, `subimage5` and `subimage8` respectively.
  - `col` increments.
  - At `col` = IMG_W-1, `col` wraps to 0 and `row` increments.
  - At the last pixel (`row` = IMG_H-1, `col` = IMG_W-1), both counters wrap to 0 and `frame_done` pulses.
- `win_valid` pulses for the accepted pixel when `row` ≥ 2 and `col` ≥ 2 at acceptance. This gives (IMG_W-2)*(IMG_H-2) windows per frame.
- Windows straddling a row boundary (`col` < 2) are never flagged valid. Stale columns from the previous row are overwritten before the next valid window.
- Cycles without an accepted pixel:
  - `win_valid` and `frame_done` are 0.
  - The subimage outputs hold their last values.
  - Counters and line buffers hold.
- No arithmetic is performed. Pixels pass through unmodified at DATA_W bits, and no sign handling is applied.

## Timing
- Latency: one cycle. For a pixel accepted at edge k, the window and `win_valid` are visible from edge k until edge k+1.
- Throughput: one pixel per cycle sustained, with no back-pressure. The downstream `muladd` must accept every `win_valid` pulse.
- Gaps in `pix_valid`, or `en` low, stall the stream losslessly. Window content depends only on accepted pixels.
- Reset values:
  - Outputs: `win_valid` = 0, `frame_done` = 0, `subimage0..8` = 0.
  - Counters: `row` = 0, `col` = 0.
  - Line-buffer contents are not cleared; they are never observed before being overwritten.
- `rst` has priority over `en`.
- A reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- Back-to-back frames: pixel (0,0) of frame N+1 may be accepted on the cycle right after the last pixel of frame N. No bubble is required.

## Structure
- Shared package `conv_pkg`:
  - `DATA_W` default (17).
  - Default image dimensions `IMG_W_DEF` and `IMG_H_DEF` (28).
  - The window size constant `KSIZE` = 3, which `muladd` also uses.
- Sub-module `line_fifo`:
  - Parameters DATA_W and DEPTH = IMG_W.
  - Enable-gated fixed-length delay line, implemented as a circular RAM with one pointer.
  - Instantiated twice, chained: lb0 feeds lb1.
- Counter widths are `$clog2(IMG_W)` and `$clog2(IMG_H)`.

## Test plan
- **Basic windows.** IMG_W=4, IMG_H=4, pixel value = 4r+c, `pix_valid` held high.
  - After pixel 10 is accepted, `win_valid`=1 and `subimage0..8` = 0,1,2,4,5,6,8,9,10.
  - Subsequent windows end at 11, 14 and 15.
  - Exactly 4 pulses per frame, then `frame_done` on the cycle of pixel 15.
- **Stalls.** Same frame with `pix_valid` low on every other cycle, and `en` low for 5 cycles mid-row.
  - Identical window sequence and values to the basic test.
  - `win_valid` is never high during a stall.
  - Outputs are stable during the stall.
- **Row boundary.** IMG_W=5, IMG_H=3, values 0..14.
  - Pixels 10 and 11 produce no `win_valid`.
  - Pixels 12, 13 and 14 produce windows whose `subimage0` = 0, 1, 2.
- **Mid-frame reset.** Assert `rst` for one cycle after 7 pixels, then send a full 4x4 frame.
  - All outputs read 0 after reset.
  - The first window again equals 0,1,2,4,5,6,8,9,10.
- **Back-to-back frames.** Two 4x4 frames streamed contiguously, second frame values = 100 + (4r+c).
  - 8 windows in total.
  - The first window of frame 2 has `subimage8` = 110 and `subimage0` = 100.
  - No stale data from frame 1 appears in frame 2's windows.
- **Width check.** Drive `pix_in` = 17'h1FFFF everywhere.
  - Every valid window outputs 17'h1FFFF on all nine lanes, with no truncation.
